// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer.
//   XLEN_DEFAULT : operand/result width (iteration count equals XLEN)
//   CNT_W        : width of the CALC iteration counter
//   F3_*         : FUNC3 encodings of the eight M-extension ops
//   state_t      : sequencer FSM states
package muldiv_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int CNT_W        = 6;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_FIXUP = 2'd2,
    S_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between the EX stage and the mul/div sequencer.
//   START, FUNC3, OPERAND_A, OPERAND_B, FLUSH : requester -> sequencer
//   BUSY, STALL, DONE, RESULT                 : sequencer -> requester
//
// Handshake: a request is taken on a rising edge where START=1, FLUSH=0 and
// the sequencer is idle; START while busy or in the DONE cycle is ignored.
// STALL is high from the requesting cycle until the DONE cycle, and RESULT is
// valid for exactly the one cycle DONE=1 (it then holds until the next DONE).
// FLUSH aborts whatever is in flight and never produces a DONE.
interface muldiv_if #(
  parameter int XLEN = 32
);
  logic            START;
  logic [2:0]      FUNC3;
  logic [XLEN-1:0] OPERAND_A;
  logic [XLEN-1:0] OPERAND_B;
  logic            FLUSH;
  logic            BUSY;
  logic            STALL;
  logic            DONE;
  logic [XLEN-1:0] RESULT;

  modport master (
    output START, FUNC3, OPERAND_A, OPERAND_B, FLUSH,
    input  BUSY, STALL, DONE, RESULT
  );

  modport slave (
    input  START, FUNC3, OPERAND_A, OPERAND_B, FLUSH,
    output BUSY, STALL, DONE, RESULT
  );
endinterface

// File: rtl/muldiv_iter_core.sv
// One-bit-per-cycle datapath for unsigned magnitudes.
//   Multiply: right-shifting shift-add, {r_hi,r_lo} becomes the 2*XLEN product.
//   Divide  : restoring divide, r_hi is the remainder, r_lo the quotient.
// Ports:
//   i_clk, i_reset : clock, synchronous active-high reset
//   i_load         : load operands (r_lo <= i_a, r_m <= i_b, r_hi <= 0)
//   i_step         : perform one iteration
//   i_is_div       : iteration type (1 = restoring divide, 0 = shift-add)
//   i_a, i_b       : multiplier/multiplicand or dividend/divisor magnitudes
//   o_prod         : product {hi,lo}
//   o_quot, o_rem  : quotient and remainder
module muldiv_iter_core
  import muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_load,
  input  logic              i_step,
  input  logic              i_is_div,
  input  logic [XLEN-1:0]   i_a,
  input  logic [XLEN-1:0]   i_b,
  output logic [2*XLEN-1:0] o_prod,
  output logic [XLEN-1:0]   o_quot,
  output logic [XLEN-1:0]   o_rem
);

  logic [XLEN-1:0] r_hi;
  logic [XLEN-1:0] r_lo;
  logic [XLEN-1:0] r_m;

  logic [XLEN:0]   w_sum;
  logic [XLEN:0]   w_shift;
  logic            w_ge;
  logic [XLEN-1:0] w_sub;

  // Shift-add: add the multiplicand when the current multiplier bit is set,
  // keep the carry, then shift the whole {carry,hi,lo} right by one.
  assign w_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_m} : '0);

  // Restoring divide: the XLEN+1 bit partial remainder is the old remainder
  // shifted left with the next dividend bit. When it is >= divisor the
  // difference is below the divisor, so XLEN bits of the subtraction suffice.
  assign w_shift = {r_hi, r_lo[XLEN-1]};
  assign w_ge    = (w_shift >= {1'b0, r_m});
  assign w_sub   = w_shift[XLEN-1:0] - r_m;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_hi <= '0;
      r_lo <= '0;
      r_m  <= '0;
    end else if (i_load) begin
      r_hi <= '0;
      r_lo <= i_a;
      r_m  <= i_b;
    end else if (i_step) begin
      if (i_is_div) begin
        r_hi <= w_ge ? w_sub : w_shift[XLEN-1:0];
        r_lo <= {r_lo[XLEN-2:0], w_ge};
      end else begin
        r_hi <= w_sum[XLEN:1];
        r_lo <= {w_sum[0], r_lo[XLEN-1:1]};
      end
    end
  end

  assign o_prod = {r_hi, r_lo};
  assign o_quot = r_lo;
  assign o_rem  = r_hi;

endmodule

// File: rtl/muldiv_sequencer.sv
// RV32M multiply/divide sequencer for the EX stage.
// Takes one op, runs XLEN iterations of muldiv_iter_core on operand
// magnitudes, applies the sign in a FIXUP cycle and pulses DONE with RESULT.
// Divide-by-zero and signed overflow finish in one cycle without iterating.
// Optional build macro: MULDIV_FAST_MUL_EN -- MUL* use a single-cycle
// signed 33x33 multiplier and go IDLE -> FIXUP directly; DIV* unchanged.
// Ports:
//   CLK, RESET   : clock, synchronous active-high reset
//   bus          : muldiv_if slave (START/FUNC3/OPERAND_A/OPERAND_B/FLUSH in,
//                  BUSY/STALL/DONE/RESULT out)
//   o_dbg_state  : current FSM state
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic      CLK,
  input  logic      RESET,
  muldiv_if.slave   bus,
  output state_t    o_dbg_state
);

  localparam logic [XLEN-1:0]   ONE      = 1;
  localparam logic [2*XLEN-1:0] PROD_ONE = 1;
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(XLEN - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = 1;
  localparam logic [XLEN-1:0]   MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  state_t           r_state;
  logic             r_busy;
  logic             r_done;
  logic [XLEN-1:0]  r_result;
  logic [2:0]       r_func3;
  logic             r_neg;
  logic [CNT_W-1:0] r_cnt;

  // ---- request decode (valid only while START is presented in IDLE) ----
  logic            w_is_div;
  logic            w_a_signed;
  logic            w_b_signed;
  logic            w_a_neg;
  logic            w_b_neg;
  logic            w_neg;
  logic [XLEN-1:0] w_mag_a;
  logic [XLEN-1:0] w_mag_b;
  logic            w_div_zero;
  logic            w_div_ovf;
  logic            w_special;
  logic [XLEN-1:0] w_special_res;
  logic            w_accept;

  assign w_is_div   = bus.FUNC3[2];
  assign w_a_signed = (bus.FUNC3 == F3_MULH) || (bus.FUNC3 == F3_MULHSU) ||
                      (bus.FUNC3 == F3_DIV)  || (bus.FUNC3 == F3_REM);
  assign w_b_signed = (bus.FUNC3 == F3_MULH) || (bus.FUNC3 == F3_DIV) ||
                      (bus.FUNC3 == F3_REM);
  assign w_a_neg    = w_a_signed & bus.OPERAND_A[XLEN-1];
  assign w_b_neg    = w_b_signed & bus.OPERAND_B[XLEN-1];
  assign w_mag_a    = w_a_neg ? (~bus.OPERAND_A + ONE) : bus.OPERAND_A;
  assign w_mag_b    = w_b_neg ? (~bus.OPERAND_B + ONE) : bus.OPERAND_B;
  // Remainder takes the dividend's sign; everything else the sign product.
  assign w_neg      = (bus.FUNC3 == F3_REM) ? w_a_neg : (w_a_neg ^ w_b_neg);

  assign w_div_zero = w_is_div && (bus.OPERAND_B == '0);
  assign w_div_ovf  = ((bus.FUNC3 == F3_DIV) || (bus.FUNC3 == F3_REM)) &&
                      (bus.OPERAND_A == MIN_NEG) && (bus.OPERAND_B == '1);
  assign w_special  = w_div_zero || w_div_ovf;
  // FUNC3[1] distinguishes REM* from DIV* within the divide group.
  always_comb begin
    w_special_res = '0;
    if (w_div_zero)
      w_special_res = bus.FUNC3[1] ? bus.OPERAND_A : '1;
    else if (w_div_ovf)
      w_special_res = bus.FUNC3[1] ? '0 : MIN_NEG;
  end

  assign w_accept = (r_state == S_IDLE) && bus.START && !bus.FLUSH;

  // ---- iterative datapath ----
  logic [2*XLEN-1:0] w_core_prod;
  logic [XLEN-1:0]   w_quot;
  logic [XLEN-1:0]   w_rem;

  muldiv_iter_core #(.XLEN(XLEN)) u_core (
    .i_clk    (CLK),
    .i_reset  (RESET),
    .i_load   (w_accept),
    .i_step   (r_state == S_CALC),
    .i_is_div (r_func3[2]),
    .i_a      (w_mag_a),
    .i_b      (w_mag_b),
    .o_prod   (w_core_prod),
    .o_quot   (w_quot),
    .o_rem    (w_rem)
  );

  logic [2*XLEN-1:0] w_prod;

`ifdef MULDIV_FAST_MUL_EN
  // Operands are sign/zero-extended to 33 bits and then replicated up to
  // 2*XLEN, so the multiply is a 33x33 signed one whose low 2*XLEN bits are
  // exactly the product the selected MUL* variant needs.
  logic signed [2*XLEN-1:0] w_fa;
  logic signed [2*XLEN-1:0] w_fb;
  logic signed [2*XLEN-1:0] w_fast;
  logic        [2*XLEN-1:0] r_fast_prod;

  assign w_fa   = {{XLEN{w_a_neg}}, bus.OPERAND_A};
  assign w_fb   = {{XLEN{w_b_neg}}, bus.OPERAND_B};
  assign w_fast = w_fa * w_fb;
  assign w_prod = r_fast_prod;
`else
  assign w_prod = w_core_prod;
`endif

  // ---- sign fixup and result selection ----
  logic [2*XLEN-1:0] w_prod_fix;
  logic [XLEN-1:0]   w_qr;
  logic [XLEN-1:0]   w_qr_fix;
  logic [XLEN-1:0]   w_fix_res;

  assign w_prod_fix = r_neg ? (~w_prod + PROD_ONE) : w_prod;
  assign w_qr       = r_func3[1] ? w_rem : w_quot;
  assign w_qr_fix   = r_neg ? (~w_qr + ONE) : w_qr;
  assign w_fix_res  = r_func3[2] ? w_qr_fix :
                      (r_func3[1:0] == 2'b00) ? w_prod_fix[XLEN-1:0] :
                                                w_prod_fix[2*XLEN-1:XLEN];

  // ---- control FSM ----
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state  <= S_IDLE;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
      r_func3  <= F3_MUL;
      r_neg    <= 1'b0;
      r_cnt    <= '0;
`ifdef MULDIV_FAST_MUL_EN
      r_fast_prod <= '0;
`endif
    end else if (bus.FLUSH) begin
      // Abort from any state; RESULT is deliberately left untouched.
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (bus.START) begin
            r_func3 <= bus.FUNC3;
            r_neg   <= w_neg;
            r_cnt   <= CNT_LOAD;
            if (w_special) begin
              r_result <= w_special_res;
              r_done   <= 1'b1;
              r_state  <= S_DONE;
            end
`ifdef MULDIV_FAST_MUL_EN
            else if (!w_is_div) begin
              // The signed multiply already carries the sign.
              r_fast_prod <= w_fast;
              r_neg       <= 1'b0;
              r_busy      <= 1'b1;
              r_state     <= S_FIXUP;
            end
`endif
            else begin
              r_busy  <= 1'b1;
              r_state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (r_cnt == '0) r_state <= S_FIXUP;
          else             r_cnt   <= r_cnt - CNT_ONE;
        end
        S_FIXUP: begin
          r_result <= w_fix_res;
          r_done   <= 1'b1;
          r_busy   <= 1'b0;
          r_state  <= S_DONE;
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.BUSY    = r_busy;
  assign bus.DONE    = r_done;
  assign bus.RESULT  = r_result;
  assign bus.STALL   = ((r_state == S_IDLE) && bus.START && !bus.FLUSH) ||
                       (r_state == S_CALC) || (r_state == S_FIXUP);
  assign o_dbg_state = r_state;

endmodule
